// File: rtl/hazard_tracker_pkg.sv
// Shared definitions for the hazard tracker and the pipeline controller:
// default widths, the in-flight slot record layout and slot commands.
package hazard_tracker_pkg;

  // Default register-file address width and stall-counter width.
  localparam int DEF_REG_ADDR_LEN = 5;
  localparam int DEF_CNT_LEN      = 16;

  // Slot record layout, MSB to LSB: {valid, dest, wb_en, mem_r_en}.
  localparam int SLOT_MR_BIT   = 0;
  localparam int SLOT_WB_BIT   = 1;
  localparam int SLOT_DEST_LSB = 2;

  // Slot indices in the tracker's slot arrays.
  localparam int SLOT_EXE = 0;
  localparam int SLOT_MEM = 1;
  localparam int NUM_SLOTS = 2;

  // Per-cycle action applied to one slot register.
  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_CLEAR = 2'd2
  } slot_cmd_e;

  // Total record width for a given register address width.
  function automatic int slot_width(input int addr_len);
    return addr_len + 3;
  endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// One in-flight pipeline slot record with load / hold / clear control.
// Clearing produces a bubble (all fields zero).
module hazard_slot_reg
  import hazard_tracker_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  slot_cmd_e    cmd_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] slot_q;
  logic [W-1:0] slot_d;

  // Select the next record from the command.
  always_comb begin
    slot_d = slot_q;
    case (cmd_i)
      SLOT_LOAD:  slot_d = d_i;
      SLOT_CLEAR: slot_d = '0;
      default:    slot_d = slot_q;
    endcase
  end

  // Slot storage; reset leaves a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/hazard_tracker.sv
// Data-hazard detector for the ID stage. Tracks the EXE and MEM slots and
// raises hazard_detected (stall + bubble) on RAW dependences; with
// forwarding active only load-use on the EXE slot stalls. Write-back is
// not tracked because the register file writes on the falling edge.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN,
  parameter int CNT_LEN      = DEF_CNT_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_two_src,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_mem_r_en,
  input  logic                    fwd_en,
  input  logic                    flush,
  input  logic                    freeze,
  output logic                    hazard_detected,
  output logic [CNT_LEN-1:0]      stall_count
);

  localparam int SLOT_W = slot_width(REG_ADDR_LEN);
  localparam logic [CNT_LEN-1:0] CNT_MAX = '1;

  logic [NUM_SLOTS-1:0][SLOT_W-1:0] slot_q;
  logic [NUM_SLOTS-1:0][SLOT_W-1:0] slot_in;
  slot_cmd_e                        slot_cmd [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]             slot_hit;
  logic [SLOT_W-1:0]                id_slot;
  logic                             hazard;
  logic                             unused_mem_mr;
  logic [CNT_LEN-1:0]               stall_cnt_q;
  logic [CNT_LEN-1:0]               stall_cnt_d;

  assign id_slot = {id_valid, id_dest, id_wb_en, id_mem_r_en};

  // EXE takes the ID instruction, MEM takes whatever leaves EXE.
  assign slot_in[SLOT_EXE] = id_slot;
  assign slot_in[SLOT_MEM] = slot_q[SLOT_EXE];

  // The MEM slot's load flag never matters: loads there are forwardable.
  assign unused_mem_mr = slot_q[SLOT_MEM][SLOT_MR_BIT];

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic                    s_valid;
      logic                    s_wb;
      logic [REG_ADDR_LEN-1:0] s_dest;

      assign s_valid = slot_q[gi][SLOT_W-1];
      assign s_wb    = slot_q[gi][SLOT_WB_BIT];
      assign s_dest  = slot_q[gi][SLOT_W-2:SLOT_DEST_LSB];

      // r0 is hard-wired zero, so a zero destination can never match.
      assign slot_hit[gi] = s_valid && s_wb && (s_dest != '0) &&
                            ((s_dest == id_src1) ||
                             (id_two_src && (s_dest == id_src2)));

      hazard_slot_reg #(
        .W(SLOT_W)
      ) u_slot (
        .clk   (clk),
        .rst   (rst),
        .cmd_i (slot_cmd[gi]),
        .d_i   (slot_in[gi]),
        .q_o   (slot_q[gi])
      );
    end
  endgenerate

  // Zero-latency hazard decision; a squashed ID instruction never stalls.
  always_comb begin
    hazard = 1'b0;
    if (id_valid && !flush) begin
      if (fwd_en) begin
        hazard = slot_hit[SLOT_EXE] && slot_q[SLOT_EXE][SLOT_MR_BIT];
      end else begin
        hazard = slot_hit[SLOT_EXE] || slot_hit[SLOT_MEM];
      end
    end
  end

  assign hazard_detected = hazard;

  // Slot commands: freeze holds everything, flush/stall inject a bubble.
  always_comb begin
    slot_cmd[SLOT_EXE] = SLOT_LOAD;
    slot_cmd[SLOT_MEM] = SLOT_LOAD;
    if (freeze) begin
      slot_cmd[SLOT_EXE] = SLOT_HOLD;
      slot_cmd[SLOT_MEM] = SLOT_HOLD;
    end else if (flush || hazard) begin
      slot_cmd[SLOT_EXE] = SLOT_CLEAR;
    end
  end

  // Saturating stall counter; frozen cycles are not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!freeze && hazard && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker. A second instance with an 8-bit
// stall counter shares the stimulus so counter saturation is reachable
// in a short run.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_two_src;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       fwd_en;
  logic       flush;
  logic       freeze;
  logic       hazard_detected;
  logic [15:0] stall_count;
  logic       hazard_sat;
  logic [7:0] stall_count_sat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_tracker u_dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_two_src      (id_two_src),
    .id_dest         (id_dest),
    .id_wb_en        (id_wb_en),
    .id_mem_r_en     (id_mem_r_en),
    .fwd_en          (fwd_en),
    .flush           (flush),
    .freeze          (freeze),
    .hazard_detected (hazard_detected),
    .stall_count     (stall_count)
  );

  hazard_tracker #(.CNT_LEN(8)) u_sat (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_two_src      (id_two_src),
    .id_dest         (id_dest),
    .id_wb_en        (id_wb_en),
    .id_mem_r_en     (id_mem_r_en),
    .fwd_en          (fwd_en),
    .flush           (flush),
    .freeze          (freeze),
    .hazard_detected (hazard_sat),
    .stall_count     (stall_count_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic two, input logic [4:0] d, input logic wb,
                        input logic mr);
    id_valid    = v;
    id_src1     = s1;
    id_src2     = s2;
    id_two_src  = two;
    id_dest     = d;
    id_wb_en    = wb;
    id_mem_r_en = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input string step);
    $display("step %s: hazard=%0b stall_count=%0d sat_count=%0d",
             step, hazard_detected, stall_count, stall_count_sat);
  endtask

  initial begin
    rst    = 1'b0;
    fwd_en = 1'b0;
    flush  = 1'b0;
    freeze = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    show("reset");
    chk("reset_hazard", 32'(hazard_detected), 32'd0);
    chk("reset_count", 32'(stall_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---- no forwarding: ADD r3 then reader of r3 stalls twice ----
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    #1;
    chk("add_issue", 32'(hazard_detected), 32'd0);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    show("raw_exe");
    chk("raw_exe", 32'(hazard_detected), 32'd1);
    tick();
    show("raw_mem");
    chk("raw_mem", 32'(hazard_detected), 32'd1);
    chk("raw_cnt1", 32'(stall_count), 32'd1);
    tick();
    show("raw_done");
    chk("raw_clear", 32'(hazard_detected), 32'd0);
    chk("raw_cnt2", 32'(stall_count), 32'd2);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();

    // ---- forwarding: load-use stalls once, ALU result does not ----
    fwd_en = 1'b1;
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    #1;
    chk("ld_issue", 32'(hazard_detected), 32'd0);
    tick();
    set_id(1'b1, 5'd4, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    #1;
    show("load_use");
    chk("load_use", 32'(hazard_detected), 32'd1);
    tick();
    show("load_use_mem");
    chk("load_use_mem", 32'(hazard_detected), 32'd0);
    chk("load_use_cnt", 32'(stall_count), 32'd3);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    #1;
    chk("fwd_add_issue", 32'(hazard_detected), 32'd0);
    tick();
    set_id(1'b1, 5'd9, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0);
    #1;
    show("fwd_add_exe");
    chk("fwd_add_exe", 32'(hazard_detected), 32'd0);
    tick();
    chk("fwd_add_mem", 32'(hazard_detected), 32'd0);
    chk("fwd_add_cnt", 32'(stall_count), 32'd3);
    fwd_en = 1'b0;
    #1;
    show("fwd_off");
    chk("fwd_off_mem", 32'(hazard_detected), 32'd1);
    fwd_en = 1'b1;
    #1;
    chk("fwd_on_again", 32'(hazard_detected), 32'd0);
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();

    // ---- r0 and unused src2 never match; flush kills the stall ----
    fwd_en = 1'b0;
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    #1;
    show("r0_read");
    chk("r0_read", 32'(hazard_detected), 32'd0);
    tick();
    set_id(1'b1, 5'd2, 5'd8, 1'b0, 5'd10, 1'b1, 1'b0);
    #1;
    show("src2_ignored");
    chk("src2_ignored", 32'(hazard_detected), 32'd0);
    id_two_src = 1'b1;
    #1;
    chk("src2_used", 32'(hazard_detected), 32'd1);
    flush = 1'b1;
    #1;
    show("flush");
    chk("flush_kills", 32'(hazard_detected), 32'd0);
    tick();
    flush = 1'b0;
    set_id(1'b1, 5'd10, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    #1;
    show("flush_bubble");
    chk("flush_bubble", 32'(hazard_detected), 32'd0);
    chk("flush_cnt", 32'(stall_count), 32'd3);

    // ---- freeze during a stall holds slots and counter ----
    tick();
    set_id(1'b1, 5'd11, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    #1;
    chk("pre_freeze", 32'(hazard_detected), 32'd1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      show("freeze");
      chk("freeze_hazard", 32'(hazard_detected), 32'd1);
      chk("freeze_cnt", 32'(stall_count), 32'd3);
    end
    freeze = 1'b0;
    tick();
    show("unfreeze");
    chk("unfreeze_hazard", 32'(hazard_detected), 32'd1);
    chk("unfreeze_cnt", 32'(stall_count), 32'd4);

    // ---- asynchronous reset mid-stall ----
    rst = 1'b0;
    #1;
    show("async_rst");
    chk("arst_hazard", 32'(hazard_detected), 32'd0);
    chk("arst_cnt", 32'(stall_count), 32'd0);
    chk("arst_sat_cnt", 32'(stall_count_sat), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_empty", 32'(hazard_detected), 32'd0);
    tick();
    set_id(1'b1, 5'd12, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    #1;
    show("post_rst");
    chk("post_rst_normal", 32'(hazard_detected), 32'd1);
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("post_rst_cnt", 32'(stall_count), 32'd0);

    // ---- saturation: self-dependent writer gives 2 stalls per 3 cycles ----
    set_id(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    for (int g = 0; g < 127; g++) begin
      tick();
      tick();
      tick();
    end
    show("sat_fe");
    chk("sat_fe", 32'(stall_count_sat), 32'hFE);
    chk("sat_main_254", 32'(stall_count), 32'd254);
    tick();
    chk("sat_issue_hz", 32'(hazard_sat), 32'd1);
    chk("sat_issue_cnt", 32'(stall_count_sat), 32'hFE);
    tick();
    show("sat_ff");
    chk("sat_ff", 32'(stall_count_sat), 32'hFF);
    chk("sat_main_255", 32'(stall_count), 32'd255);
    tick();
    chk("sat_hold", 32'(stall_count_sat), 32'hFF);
    chk("sat_main_256", 32'(stall_count), 32'd256);
    chk("sat_hz_done", 32'(hazard_sat), 32'd0);
    for (int g = 0; g < 3; g++) begin
      tick();
      tick();
      tick();
    end
    show("sat_stays");
    chk("sat_stays", 32'(stall_count_sat), 32'hFF);
    chk("sat_main_262", 32'(stall_count), 32'd262);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have parameter REG_ADDR_LEN, default 5, register-file address width.
REQ-002 SHALL have parameter CNT_LEN, default 16, stall-counter width.
REQ-003 SHALL have ports, in this order:
- clk  input  1  rising-edge clock, the block's only clock
- rst  input  1  asynchronous, active-low reset
- id_valid  input  1  ID stage holds a real instruction
- id_src1  input  REG_ADDR_LEN  first source register
- id_src2  input  REG_ADDR_LEN  second source register
- id_two_src  input  1  src2 is read (R-type, ST, BNE)
- id_dest  input  REG_ADDR_LEN  destination register
- id_wb_en  input  1  instruction writes the register file
- id_mem_r_en  input  1  instruction is a load
- fwd_en  input  1  forwarding unit active
- flush  input  1  branch taken in EXE; ID instruction squashed
- freeze  input  1  memory wait; whole pipeline holds
- hazard_detected  output  1  stall ID, insert bubble (to controller)
- stall_count  output  CNT_LEN  saturating count of stall cycles

Function
REQ-004 SHALL hold two in-flight slots, EXE and MEM; each slot holds valid, dest, wb_en, mem_r_en.
REQ-005 SHALL treat register 0 as never hazardous: source or destination 0 never matches.
REQ-006 SHALL define a source match as slot.valid AND slot.wb_en AND slot.dest == src, with src2 checked only when id_two_src=1.
REQ-007 With fwd_en=0, SHALL assert hazard_detected when id_valid=1 and any source matches the EXE slot or the MEM slot.
REQ-008 With fwd_en=1, SHALL assert hazard_detected only when id_valid=1 and a source matches the EXE slot with EXE.mem_r_en=1 (load-use).
REQ-009 SHALL compute hazard_detected combinationally from current slot contents and ID inputs, with zero-cycle latency.
REQ-010 SHALL force hazard_detected=0 while flush=1.
REQ-011 The WB stage SHALL NOT be tracked; the register file writes on the falling edge, so write-back never causes a hazard.
REQ-012 SHALL apply the following slot update at each rising clk edge, highest priority first:
- freeze=1: EXE and MEM slots hold; stall_count holds.
- flush=1: MEM slot <= EXE slot; EXE slot <= bubble.
- hazard_detected=1: MEM slot <= EXE slot; EXE slot <= bubble; stall_count increments.
- otherwise: MEM slot <= EXE slot; EXE slot <= {id_valid, id_dest, id_wb_en, id_mem_r_en}.
REQ-013 A bubble SHALL be all fields 0.
REQ-014 stall_count SHALL saturate at all-ones and never wrap.
REQ-015 fwd_en SHALL be sampled every cycle; a mid-run change affects the hazard decision in the same cycle only and does not alter slot contents.

Reset
REQ-016 rst=0 SHALL asynchronously clear both slots to bubble and stall_count to 0, so hazard_detected reads 0 immediately.
REQ-017 Reset asserted mid-stall SHALL drop hazard_detected in the same cycle, with no partial slot state retained.
REQ-018 After rst rises, the first clk edge SHALL follow REQ-012 normally.

Structure
REQ-019 REG_ADDR_LEN default and the slot-record field layout SHALL come from the shared defines file (defines.v) used by the controller.
REQ-020 SHALL contain one sub-module, hazard_slot_reg, used for both the EXE and MEM slots; it provides load, hold and clear behaviour with asynchronous active-low reset.

Verification
REQ-021 Bench SHALL cover: fwd_en=0; ADD r3 issued, next ID reads r3 (src1) -> hazard_detected=1 for 2 cycles, then 0; stall_count=2.
REQ-022 Bench SHALL cover: fwd_en=1; LD r4, next ID reads r4 -> exactly 1 stall cycle; ADD r4 followed by a reader of r4 -> 0 stalls.
REQ-023 Bench SHALL cover: dest=0 writer followed by a reader of r0, and id_two_src=0 with src2 matching -> hazard_detected=0 in both cases.
REQ-024 Bench SHALL cover: hazard active when flush=1 -> hazard_detected=0 in that cycle; next cycle EXE slot is a bubble; freeze=1 for 3 cycles during a stall -> slots and stall_count unchanged.
REQ-025 Bench SHALL cover: preload stall_count to 0xFFFE via continuous stalls -> it reaches 0xFFFF and stays there.
REQ-026 Bench SHALL cover: rst=0 asserted asynchronously mid-stall -> hazard_detected=0 and stall_count=0 before the next clk edge.
